// File: rtl/regfile_writeback_pkg.sv
// rtl/regfile_writeback_pkg.sv - shared CPU constants and types for the write-back unit
package regfile_writeback_pkg;

    localparam logic [1:0] DST_R31 = 2'd0;
    localparam logic [1:0] DST_RT  = 2'd1;
    localparam logic [1:0] DST_RD  = 2'd2;

    localparam logic [4:0] REG_LINK = 5'd31;

    localparam int WB_DATA_W = 32;

    typedef struct packed {
        logic [4:0]           addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry;

    // Destination selection; encoding 3 falls back to the link register like 0.
    function automatic logic [4:0] resolve_addr(input logic [1:0] sel,
                                                input logic [4:0] rt,
                                                input logic [4:0] rd);
        logic [4:0] addr;
        case (sel)
            DST_RT:  addr = rt;
            DST_RD:  addr = rd;
            default: addr = REG_LINK;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// rtl/regfile_writeback_wb_fifo.sv - generic circular FIFO with flush, count and per-slot key view
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37,
    parameter int KW    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [DEPTH*KW-1:0]      keys,
    output logic [DEPTH-1:0]         valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  last_q, last_d;
    logic          do_push;
    logic          do_pop;

    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    // When empty, the last popped entry is shown so the write port stays quiet.
    assign head_data = (count_q != '0) ? mem_q[head_q] : last_q;

    // Next-state: flush wins; otherwise push and pop may both happen.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        last_d  = last_q;
        do_push = push && !full;
        do_pop  = pop && (count_q != '0);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + 1'b1;
            end
            if (do_pop) begin
                last_d = mem_q[head_q];
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Slot i is occupied when its distance from head is below count.
    always_comb begin
        keys  = '0;
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off = PW'(i) - head_q;
            valid[i] = ({1'b0, off} < count_q);
            keys[i*KW +: KW] = mem_q[i][W-1 -: KW];
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - buffered register-file write port with pending-write scoreboard
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_dst_sel,
    input  logic [4:0]              in_rt,
    input  logic [4:0]              in_rd,
    input  logic                    in_link,
    input  logic                    in_hw,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [DATA_W-1:0]       in_pc4,
    input  logic                    flush,
    input  logic                    wr_stall,
    output logic                    wr_en,
    output logic [4:0]              wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    input  logic [4:0]              q_rs,
    input  logic [4:0]              q_rt,
    output logic                    busy_rs,
    output logic                    busy_rt,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int W  = 5 + DATA_W;
    localparam int HW = DATA_W / 2;

    logic [4:0]         res_addr;
    logic [DATA_W-1:0]  res_data;
    logic               push;
    logic               full;
    logic [W-1:0]       head_data;
    logic [DEPTH*5-1:0] keys;
    logic [DEPTH-1:0]   valid;

    // Resolve destination register and data shaping at push time.
    always_comb begin
        res_addr = resolve_addr(in_dst_sel, in_rt, in_rd);
        if (in_link)
            res_data = in_pc4;
        else if (in_hw)
            res_data = {{(DATA_W-HW){1'b0}}, in_data[DATA_W-1:HW]};
        else
            res_data = in_data;
    end

    // Writes to r0 are accepted but never occupy a slot.
    assign in_ready = !full;
    assign push     = in_valid && in_ready && !flush && (res_addr != 5'd0);
    assign wr_en    = (count != '0) && !wr_stall && !flush;
    assign wr_addr  = head_data[W-1 -: 5];
    assign wr_data  = head_data[DATA_W-1:0];

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (W),
        .KW    (5)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data ({res_addr, res_data}),
        .pop       (wr_en),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .keys      (keys),
        .valid     (valid)
    );

    // Scoreboard compare over stored entries only; r0 is never busy.
    always_comb begin
        busy_rs = 1'b0;
        busy_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (keys[i*5 +: 5] == q_rs) && (q_rs != 5'd0)) busy_rs = 1'b1;
            if (valid[i] && (keys[i*5 +: 5] == q_rt) && (q_rt != 5'd0)) busy_rt = 1'b1;
        end
    end

endmodule
